ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register of the pipelined MIPS core.
- Consumes the ID/EX register outputs, resolves data hazards by forwarding from EX/MEM (internal) and MEM/WB (ports), and computes the ALU result and destination register.
- Registers everything the MEM stage needs on posedge clk.
- This block sits on the read side of the ID/EX interface; it is the sole consumer of the ID/EX control and data fields.

Parameters:
- DATA_W, 32, datapath width.
- RA_REG, 31, destination register index when RegDst selects link.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  convert the instruction entering EX/MEM into a bubble.
- AluSrc, RegWrite, MemRead, MemWrite  in  1 each  ID/EX control fields.
- RegDst  in  2  00 Rt, 01 Rd, 10 RA_REG, 11 Rt.
- MemToReg  in  2  passed through; 10 marks a link (PC+4) writeback.
- AluOp  in  3  000 add, 001 sub, 010 and, 011 or, 100 slt (signed), others add.
- Rs, Rt, Rd  in  5 each  ID/EX register indices.
- adderPcOut, readData1, readData2, signExtend  in  DATA_W each  ID/EX data fields.
- wbRegWrite  in  1  MEM/WB write enable.
- wbDest  in  5  MEM/WB destination index.
- wbData  in  DATA_W  final MEM/WB writeback value.
- RegWriteEXMEM, MemReadEXMEM, MemWriteEXMEM  out  1 each  registered control.
- MemToRegEXMEM  out  2  registered control.
- aluResultEXMEM  out  DATA_W  registered ALU result.
- writeDataEXMEM  out  DATA_W  forwarded Rt operand, used as store data.
- adderPcOutEXMEM  out  DATA_W  registered PC+4.
- destRegEXMEM  out  5  registered destination index.
- zeroEXMEM  out  1  registered (ALU result == 0).
- fwdA, fwdB  out  2 each  combinational forwarding selects: 00 register file, 01 MEM/WB, 10 EX/MEM.

Behaviour:
- Reset: on posedge clk with rst=1, every registered output becomes 0. rst has priority over flush.
- Latency: 1 cycle. Inputs present in cycle N appear on the EXMEM outputs after edge N+1.
- EX/MEM forward value (exFwd):
  - adderPcOutEXMEM when MemToRegEXMEM==10.
  - aluResultEXMEM otherwise.
  - Load-use hazards are stalled upstream; this block never waits on memory data.
- Forward A:
  - fwdA=10 if RegWriteEXMEM and destRegEXMEM!=0 and destRegEXMEM==Rs.
  - else fwdA=01 if wbRegWrite and wbDest!=0 and wbDest==Rs.
  - else fwdA=00.
  - EX/MEM wins when both match.
- Forward B: identical rules using Rt.
- Operand selection:
  - opA = forwarded Rs value.
  - fwdRt = forwarded Rt value.
  - opB = signExtend if AluSrc, else fwdRt.
- ALU arithmetic:
  - add/sub wrap modulo 2^DATA_W; no overflow trap.
  - slt gives 1 if $signed(opA) < $signed(opB), else 0, zero-extended.
- Destination: selected per RegDst. A destination of 0 is registered as-is; writes to register 0 are suppressed downstream, and index 0 never forwards.
- Normal capture:
  - control outputs <= inputs.
  - aluResultEXMEM <= ALU result.
  - writeDataEXMEM <= fwdRt.
  - adderPcOutEXMEM <= adderPcOut.
  - destRegEXMEM <= selected destination.
  - zeroEXMEM <= (ALU result == 0).
- Flush:
  - RegWriteEXMEM, MemReadEXMEM, MemWriteEXMEM, MemToRegEXMEM <= 0.
  - Data fields still capture normally; they are don't-care but deterministic.
  - Forwarding in the following cycle must not select the bubble, since RegWriteEXMEM=0.
- Back-to-back dependency: the instruction in EX/MEM forwards to the immediately following instruction with no bubble.
- Simultaneous events: when wbDest==destRegEXMEM==Rs, the EX/MEM value is used.
- Reset mid-stream: an in-flight instruction is discarded. The first cycle after reset cannot forward from EX/MEM because RegWriteEXMEM=0.

Test Plan:
- Reset: drive arbitrary inputs with rst=1 for 2 cycles -> all EXMEM outputs 0; fwdA=fwdB=00.
- Basic R-type: readData1=5, readData2=7, AluOp=000, RegDst=01, Rd=9, RegWrite=1 -> next cycle aluResultEXMEM=12, destRegEXMEM=9, zeroEXMEM=0.
- EX/MEM forwarding:
  - Setup: prior instruction writes r9=12; next instruction has Rs=9, readData1=0, readData2=12, AluOp=001.
  - Response: fwdA=10, aluResultEXMEM=0, zeroEXMEM=1.
- Priority: EX/MEM dest=4 holds 100, wbDest=4 with wbData=55, next Rs=4 -> fwdA=10, opA=100. Repeat with the EX/MEM instruction flushed -> fwdA=01, opA=55.
- Register 0 and slt:
  - Setup: wbRegWrite=1, wbDest=0, Rt=0, readData2=0, readData1=32'hFFFFFFFF, AluOp=100.
  - Response: fwdB=00, aluResultEXMEM=1.
- Link forwarding and store data:
  - Setup: jal with MemToReg=10, RegDst=10, adderPcOut=0x40; next instruction is sw with AluSrc=1, Rt=31, signExtend=8, readData1=0x100.
  - Response: destRegEXMEM=31; next cycle writeDataEXMEM=0x40, aluResultEXMEM=0x108, MemWriteEXMEM=1.

Source files
------------

// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM forwarding, ALU and destination select, registered into EX/MEM.
// One cycle of latency and no backpressure; flush turns the captured instruction into a bubble.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int RA_REG = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              AluSrc,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        RegDst,
  input  logic [1:0]        MemToReg,
  input  logic [2:0]        AluOp,
  input  logic [4:0]        Rs,
  input  logic [4:0]        Rt,
  input  logic [4:0]        Rd,
  input  logic [DATA_W-1:0] adderPcOut,
  input  logic [DATA_W-1:0] readData1,
  input  logic [DATA_W-1:0] readData2,
  input  logic [DATA_W-1:0] signExtend,
  input  logic              wbRegWrite,
  input  logic [4:0]        wbDest,
  input  logic [DATA_W-1:0] wbData,
  output logic              RegWriteEXMEM,
  output logic              MemReadEXMEM,
  output logic              MemWriteEXMEM,
  output logic [1:0]        MemToRegEXMEM,
  output logic [DATA_W-1:0] aluResultEXMEM,
  output logic [DATA_W-1:0] writeDataEXMEM,
  output logic [DATA_W-1:0] adderPcOutEXMEM,
  output logic [4:0]        destRegEXMEM,
  output logic              zeroEXMEM,
  output logic [1:0]        fwdA,
  output logic [1:0]        fwdB
);

  localparam logic [4:0] RA_IDX = 5'(RA_REG);

  logic [DATA_W-1:0] exFwd;
  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] fwdRt;
  logic [DATA_W-1:0] opB;
  logic [DATA_W-1:0] aluResult;
  logic [4:0]        destReg;

  // A link instruction in EX/MEM carries its result in the PC+4 field.
  assign exFwd = (MemToRegEXMEM == 2'b10) ? adderPcOutEXMEM : aluResultEXMEM;

  always_comb begin
    fwdA = 2'b00;
    if (RegWriteEXMEM && (destRegEXMEM != 5'd0) && (destRegEXMEM == Rs))
      fwdA = 2'b10;
    else if (wbRegWrite && (wbDest != 5'd0) && (wbDest == Rs))
      fwdA = 2'b01;
  end

  always_comb begin
    fwdB = 2'b00;
    if (RegWriteEXMEM && (destRegEXMEM != 5'd0) && (destRegEXMEM == Rt))
      fwdB = 2'b10;
    else if (wbRegWrite && (wbDest != 5'd0) && (wbDest == Rt))
      fwdB = 2'b01;
  end

  always_comb begin
    case (fwdA)
      2'b10:   opA = exFwd;
      2'b01:   opA = wbData;
      default: opA = readData1;
    endcase
    case (fwdB)
      2'b10:   fwdRt = exFwd;
      2'b01:   fwdRt = wbData;
      default: fwdRt = readData2;
    endcase
    opB = AluSrc ? signExtend : fwdRt;
  end

  always_comb begin
    case (AluOp)
      3'b001:  aluResult = opA - opB;
      3'b010:  aluResult = opA & opB;
      3'b011:  aluResult = opA | opB;
      3'b100:  aluResult = {{(DATA_W-1){1'b0}}, ($signed(opA) < $signed(opB))};
      default: aluResult = opA + opB;
    endcase
  end

  always_comb begin
    case (RegDst)
      2'b01:   destReg = Rd;
      2'b10:   destReg = RA_IDX;
      default: destReg = Rt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteEXMEM   <= 1'b0;
      MemReadEXMEM    <= 1'b0;
      MemWriteEXMEM   <= 1'b0;
      MemToRegEXMEM   <= 2'b00;
      aluResultEXMEM  <= '0;
      writeDataEXMEM  <= '0;
      adderPcOutEXMEM <= '0;
      destRegEXMEM    <= 5'd0;
      zeroEXMEM       <= 1'b0;
    end else begin
      // Data fields capture even on flush so the bubble stays deterministic.
      RegWriteEXMEM   <= flush ? 1'b0  : RegWrite;
      MemReadEXMEM    <= flush ? 1'b0  : MemRead;
      MemWriteEXMEM   <= flush ? 1'b0  : MemWrite;
      MemToRegEXMEM   <= flush ? 2'b00 : MemToReg;
      aluResultEXMEM  <= aluResult;
      writeDataEXMEM  <= fwdRt;
      adderPcOutEXMEM <= adderPcOut;
      destRegEXMEM    <= destReg;
      zeroEXMEM       <= (aluResult == '0);
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: expected EX/MEM contents are queued as each
// instruction is driven and compared one cycle later; forwarding selects are checked in-cycle.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst, flush, AluSrc, RegWrite, MemRead, MemWrite;
  logic [1:0]  RegDst, MemToReg;
  logic [2:0]  AluOp;
  logic [4:0]  Rs, Rt, Rd, wbDest;
  logic [31:0] adderPcOut, readData1, readData2, signExtend, wbData;
  logic        wbRegWrite;
  logic        RegWriteEXMEM, MemReadEXMEM, MemWriteEXMEM, zeroEXMEM;
  logic [1:0]  MemToRegEXMEM, fwdA, fwdB;
  logic [31:0] aluResultEXMEM, writeDataEXMEM, adderPcOutEXMEM;
  logic [4:0]  destRegEXMEM;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        rw;
    logic        mr;
    logic        mw;
    logic [1:0]  mtr;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic        zero;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .AluSrc(AluSrc), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegDst(RegDst), .MemToReg(MemToReg), .AluOp(AluOp),
    .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .adderPcOut(adderPcOut), .readData1(readData1), .readData2(readData2),
    .signExtend(signExtend),
    .wbRegWrite(wbRegWrite), .wbDest(wbDest), .wbData(wbData),
    .RegWriteEXMEM(RegWriteEXMEM), .MemReadEXMEM(MemReadEXMEM),
    .MemWriteEXMEM(MemWriteEXMEM), .MemToRegEXMEM(MemToRegEXMEM),
    .aluResultEXMEM(aluResultEXMEM), .writeDataEXMEM(writeDataEXMEM),
    .adderPcOutEXMEM(adderPcOutEXMEM), .destRegEXMEM(destRegEXMEM),
    .zeroEXMEM(zeroEXMEM), .fwdA(fwdA), .fwdB(fwdB)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic nop();
    rst = 1'b0; flush = 1'b0; AluSrc = 1'b0; RegWrite = 1'b0; MemRead = 1'b0;
    MemWrite = 1'b0; RegDst = 2'b00; MemToReg = 2'b00; AluOp = 3'b000;
    Rs = 5'd0; Rt = 5'd0; Rd = 5'd0; adderPcOut = '0; readData1 = '0;
    readData2 = '0; signExtend = '0; wbRegWrite = 1'b0; wbDest = 5'd0; wbData = '0;
  endtask

  task automatic push(input logic rw, input logic mr, input logic mw, input logic [1:0] mtr,
                      input logic [31:0] alu, input logic [31:0] wdata, input logic [31:0] pc,
                      input logic [4:0] dest, input logic zero);
    exp_t e;
    e.rw = rw; e.mr = mr; e.mw = mw; e.mtr = mtr; e.alu = alu;
    e.wdata = wdata; e.pc = pc; e.dest = dest; e.zero = zero;
    sb.push_back(e);
  endtask

  // Advance one edge, then compare EX/MEM against the oldest queued expectation.
  task automatic tick(input string step);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({step, ".sb_underflow"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({step, ".RegWrite"}, 32'(RegWriteEXMEM), 32'(e.rw));
      check({step, ".MemRead"},  32'(MemReadEXMEM),  32'(e.mr));
      check({step, ".MemWrite"}, 32'(MemWriteEXMEM), 32'(e.mw));
      check({step, ".MemToReg"}, 32'(MemToRegEXMEM), 32'(e.mtr));
      check({step, ".alu"},      aluResultEXMEM,     e.alu);
      check({step, ".wdata"},    writeDataEXMEM,     e.wdata);
      check({step, ".pc"},       adderPcOutEXMEM,    e.pc);
      check({step, ".dest"},     32'(destRegEXMEM),  32'(e.dest));
      check({step, ".zero"},     32'(zeroEXMEM),     32'(e.zero));
    end
  endtask

  initial begin
    nop();
    #1;
    // Reset with busy inputs
    rst = 1'b1; RegWrite = 1'b1; MemRead = 1'b1; MemWrite = 1'b1; MemToReg = 2'b10;
    RegDst = 2'b01; Rd = 5'd9; Rs = 5'd3; Rt = 5'd4; readData1 = 32'h1234_5678;
    readData2 = 32'h0BAD_F00D; adderPcOut = 32'h0000_0ABC; wbRegWrite = 1'b1; wbDest = 5'd7;
    push(0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 0);
    tick("rst1");
    push(0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 0);
    tick("rst2");
    check("rst.fwdA", 32'(fwdA), 32'd0);
    check("rst.fwdB", 32'(fwdB), 32'd0);

    // Basic R-type add: r9 = 5 + 7
    nop();
    Rs = 5'd1; Rt = 5'd2; Rd = 5'd9; RegDst = 2'b01; RegWrite = 1'b1;
    readData1 = 32'd5; readData2 = 32'd7; adderPcOut = 32'h10;
    #1;
    check("rtype.fwdA", 32'(fwdA), 32'd0);
    check("rtype.fwdB", 32'(fwdB), 32'd0);
    push(1, 0, 0, 2'b00, 32'd12, 32'd7, 32'h10, 5'd9, 0);
    tick("rtype");

    // Back-to-back EX/MEM forward: r10 = r9 - 12
    nop();
    Rs = 5'd9; Rt = 5'd3; Rd = 5'd10; RegDst = 2'b01; RegWrite = 1'b1; AluOp = 3'b001;
    readData1 = 32'd0; readData2 = 32'd12;
    #1;
    check("exfwd.fwdA", 32'(fwdA), 32'd2);
    check("exfwd.fwdB", 32'(fwdB), 32'd0);
    push(1, 0, 0, 2'b00, 32'd0, 32'd12, 32'h0, 5'd10, 1);
    tick("exfwd");

    // r4 = 100 via or
    nop();
    Rd = 5'd4; RegDst = 2'b01; RegWrite = 1'b1; AluOp = 3'b011; readData1 = 32'd100;
    push(1, 0, 0, 2'b00, 32'd100, 32'd0, 32'h0, 5'd4, 0);
    tick("r4set");

    // EX/MEM and MEM/WB both hold r4: EX/MEM wins
    nop();
    Rs = 5'd4; Rt = 5'd5; MemRead = 1'b1; readData1 = 32'd1; readData2 = 32'd3;
    wbRegWrite = 1'b1; wbDest = 5'd4; wbData = 32'd55;
    #1;
    check("prio.fwdA", 32'(fwdA), 32'd2);
    push(0, 1, 0, 2'b00, 32'd103, 32'd3, 32'h0, 5'd5, 0);
    tick("prio");

    // Same r4 writer, flushed into a bubble
    nop();
    flush = 1'b1; Rd = 5'd4; RegDst = 2'b01; RegWrite = 1'b1; MemWrite = 1'b1;
    MemToReg = 2'b01; AluOp = 3'b011; readData1 = 32'd100;
    push(0, 0, 0, 2'b00, 32'd100, 32'd0, 32'h0, 5'd4, 0);
    tick("flush");

    // Bubble must not forward; MEM/WB supplies r4
    nop();
    Rs = 5'd4; Rt = 5'd5; readData1 = 32'd1; readData2 = 32'd3;
    wbRegWrite = 1'b1; wbDest = 5'd4; wbData = 32'd55;
    #1;
    check("wbfwd.fwdA", 32'(fwdA), 32'd1);
    push(0, 0, 0, 2'b00, 32'd58, 32'd3, 32'h0, 5'd5, 0);
    tick("wbfwd");

    // MEM/WB writing r0 must not forward; slt(-1, 0) = 1
    nop();
    Rs = 5'd6; Rt = 5'd0; RegWrite = 1'b1; AluOp = 3'b100;
    readData1 = 32'hFFFF_FFFF; readData2 = 32'd0;
    wbRegWrite = 1'b1; wbDest = 5'd0; wbData = 32'd77;
    #1;
    check("r0.fwdB", 32'(fwdB), 32'd0);
    check("r0.fwdA", 32'(fwdA), 32'd0);
    push(1, 0, 0, 2'b00, 32'd1, 32'd0, 32'h0, 5'd0, 0);
    tick("slt");

    // jal: EX/MEM holds dest 0 with RegWrite, which must not forward to Rs=0
    nop();
    RegWrite = 1'b1; MemToReg = 2'b10; RegDst = 2'b10; AluOp = 3'b111; adderPcOut = 32'h40;
    #1;
    check("jal.fwdA", 32'(fwdA), 32'd0);
    push(1, 0, 0, 2'b10, 32'd0, 32'd0, 32'h40, 5'd31, 1);
    tick("jal");

    // sw after jal: store data is the forwarded link value
    nop();
    AluSrc = 1'b1; MemWrite = 1'b1; Rs = 5'd2; Rt = 5'd31; signExtend = 32'd8;
    readData1 = 32'h100; readData2 = 32'h0000_DEAD; adderPcOut = 32'h44;
    #1;
    check("sw.fwdB", 32'(fwdB), 32'd2);
    check("sw.fwdA", 32'(fwdA), 32'd0);
    push(0, 0, 1, 2'b00, 32'h108, 32'h40, 32'h44, 5'd31, 0);
    tick("sw");

    // r12 = 0xF0F0 & 0xFF00, then a reset discards the next in-flight writer
    nop();
    Rs = 5'd1; Rt = 5'd2; Rd = 5'd12; RegDst = 2'b01; RegWrite = 1'b1; AluOp = 3'b010;
    readData1 = 32'h0000_F0F0; readData2 = 32'h0000_FF00;
    push(1, 0, 0, 2'b00, 32'h0000_F000, 32'h0000_FF00, 32'h0, 5'd12, 0);
    tick("and");
    nop();
    rst = 1'b1; flush = 1'b1; Rd = 5'd12; RegDst = 2'b01; RegWrite = 1'b1; readData1 = 32'd9;
    push(0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 0);
    tick("midrst");

    // First cycle after reset: no EX/MEM forward; 2 - 3 wraps
    nop();
    Rs = 5'd12; Rt = 5'd12; Rd = 5'd13; RegDst = 2'b01; RegWrite = 1'b1; AluOp = 3'b001;
    readData1 = 32'd2; readData2 = 32'd3;
    #1;
    check("postrst.fwdA", 32'(fwdA), 32'd0);
    check("postrst.fwdB", 32'(fwdB), 32'd0);
    push(1, 0, 0, 2'b00, 32'hFFFF_FFFF, 32'd3, 32'h0, 5'd13, 0);
    tick("postrst");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
